// File: rtl/bira_pkg.sv
// Shared definitions for the built-in redundancy analysis blocks.
// Holds the sweep FSM state type, the default DSSS/RLSS widths and
// popcounts, the first/last candidate words and a helper that returns
// the total number of (DSSS, RLSS) candidates. The signal validity
// checker reuses the same constants.
package bira_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned DsssW = 8;
    localparam int unsigned DsssK = 4;
    localparam int unsigned RlssW = 4;
    localparam int unsigned RlssK = 2;

    // Smallest and largest words with the required popcount.
    localparam logic [DsssW-1:0] DsssStart = 8'h0F;
    localparam logic [DsssW-1:0] DsssLast  = 8'hF0;
    localparam logic [RlssW-1:0] RlssStart = 4'h3;
    localparam logic [RlssW-1:0] RlssLast  = 4'hC;

    // Binomial coefficient; only ever evaluated at elaboration time.
    function automatic int unsigned n_choose_k(input int unsigned n, input int unsigned k);
        int unsigned res;
        res = 1;
        for (int unsigned i = 0; i < k; i++) begin
            res = res * (n - i) / (i + 1);
        end
        return res;
    endfunction

    function automatic int unsigned total_candidates(input int unsigned dw, input int unsigned dk,
                                                     input int unsigned rw, input int unsigned rk);
        return n_choose_k(dw, dk) * n_choose_k(rw, rk);
    endfunction

endpackage

// File: rtl/popcount_successor.sv
// Combinational Gosper step: returns the next larger word with the same
// number of set bits as x.
//   x    : current word (W bits, nonzero)
//   next : successor with equal popcount (wraps/overflows past the largest)
// The divide by the lowest set bit is replaced by a right shift by its
// position, found with a priority encoder.
module popcount_successor #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] next
);

    localparam int unsigned LW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  low_bit;
    logic [W-1:0]  ripple;
    logic [LW-1:0] low_pos;

    always_comb begin
        low_bit = x & (~x + W'(1));
        ripple  = x + low_bit;
        low_pos = '0;
        // low_bit is one-hot, so at most one iteration matches
        for (int i = 0; i < int'(W); i++) begin
            if (low_bit[i]) begin
                low_pos = LW'(i);
            end
        end
        next = ripple | (((ripple ^ x) >> 2) >> low_pos);
    end

endmodule

// File: rtl/spare_candidate_generator.sv
// Enumerates every (DSSS, RLSS) spare-allocation candidate for the
// redundancy analyser over a valid/ready handshake, RLSS innermost, each
// word stepping through increasing values of fixed popcount.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : begin a sweep (IDLE only)
//   abort            : return to IDLE from any state, no done pulse
//   out_ready        : consumer accepts current candidate
//   out_valid        : dsss/rlss/cand_idx hold a valid candidate
//   dsss, rlss       : current candidate words
//   cand_idx         : 0-based ordinal of the current candidate
//   busy             : high while sweeping
//   done             : one-cycle pulse after the last candidate transfers
module spare_candidate_generator
    import bira_pkg::*;
#(
    parameter int unsigned DSSS_W = DsssW,
    parameter int unsigned DSSS_K = DsssK,
    parameter int unsigned RLSS_W = RlssW,
    parameter int unsigned RLSS_K = RlssK,
    parameter int unsigned IDX_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DSSS_W-1:0] dsss,
    output logic [RLSS_W-1:0] rlss,
    output logic [IDX_W-1:0]  cand_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [DSSS_W-1:0] DsssFirst = ~({DSSS_W{1'b1}} << DSSS_K);
    localparam logic [RLSS_W-1:0] RlssFirst = ~({RLSS_W{1'b1}} << RLSS_K);
    localparam logic [RLSS_W-1:0] RlssMax   = RlssFirst << (RLSS_W - RLSS_K);
    localparam int unsigned       NumCand   = total_candidates(DSSS_W, DSSS_K, RLSS_W, RLSS_K);
    localparam logic [IDX_W-1:0]  LastIdx   = IDX_W'(NumCand - 1);

    state_e            state;
    logic [DSSS_W-1:0] dsss_next;
    logic [RLSS_W-1:0] rlss_next;
    logic              xfer;

    assign xfer = out_valid && out_ready;

    popcount_successor #(
        .W(DSSS_W)
    ) u_dsss_succ (
        .x   (dsss),
        .next(dsss_next)
    );

    popcount_successor #(
        .W(RLSS_W)
    ) u_rlss_succ (
        .x   (rlss),
        .next(rlss_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dsss      <= '0;
            rlss      <= '0;
            cand_idx  <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Candidate registers deliberately keep their last values.
                state     <= StIdle;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start) begin
                            dsss      <= DsssFirst;
                            rlss      <= RlssFirst;
                            cand_idx  <= '0;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= StRun;
                        end
                    end
                    StRun: begin
                        if (xfer) begin
                            if (cand_idx == LastIdx) begin
                                out_valid <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                state     <= StDone;
                            end else begin
                                cand_idx <= cand_idx + IDX_W'(1);
                                if (rlss == RlssMax) begin
                                    rlss <= RlssFirst;
                                    dsss <= dsss_next;
                                end else begin
                                    rlss <= rlss_next;
                                end
                            end
                        end
                    end
                    StDone: begin
                        state <= StIdle;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
